// File: rtl/mac_fp4_dot_sequencer_if.sv
// mac_fp4_dot_sequencer_if: command, operand, MAC and result signals of one dot-product sequencer
interface mac_fp4_dot_sequencer_if #(
  parameter int LEN_WIDTH = 9,
  parameter int ACC_WIDTH = 17
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 op_valid;
  logic                 op_ready;
  logic [3:0]           op_weight;
  logic [3:0]           op_act;
  logic                 mac_en;
  logic                 mac_clear;
  logic [3:0]           mac_weight;
  logic [3:0]           mac_act;
  logic [ACC_WIDTH-1:0] mac_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_WIDTH-1:0] res_data;
  logic [LEN_WIDTH-1:0] res_count;
  logic                 busy;
  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_weight, op_act, mac_out, res_ready,
    output cmd_ready, op_ready, mac_en, mac_clear, mac_weight, mac_act, res_valid, res_data, res_count, busy
  );
  modport master (
    output cmd_valid, cmd_len, op_valid, op_weight, op_act, mac_out, res_ready,
    input  cmd_ready, op_ready, mac_en, mac_clear, mac_weight, mac_act, res_valid, res_data, res_count, busy
  );
endinterface

// File: rtl/mac_fp4_dot_sequencer.sv
// mac_fp4_dot_sequencer: drives one fp4 MAC through clear, stream, drain and result capture per job
module mac_fp4_dot_sequencer #(
  parameter int LEN_WIDTH  = 9,
  parameter int ACC_WIDTH  = 17,
  parameter int MAC_LAT    = 2,
  parameter int CLR_CYCLES = 2
) (
  input logic                    clk,
  input logic                    reset_n,
  mac_fp4_dot_sequencer_if.slave s
);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam int DW = $clog2(MAC_LAT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
  state_t               state_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [CW-1:0]        clr_cnt_q;
  logic [DW-1:0]        drn_cnt_q;
  logic                 cmd_ready_q;
  logic                 clr_q;
  logic                 res_valid_q;
  logic                 busy_q;
  logic [ACC_WIDTH-1:0] res_data_q;
  logic [LEN_WIDTH-1:0] res_count_q;
  logic                 take;
  assign take         = state_q == STREAM && s.op_valid;
  assign s.op_ready   = state_q == STREAM;
  assign s.mac_en     = take || state_q == DRAIN;
  assign s.mac_weight = take ? s.op_weight : 4'h0;
  assign s.mac_act    = take ? s.op_act : 4'h0;
  assign s.mac_clear  = clr_q;
  assign s.cmd_ready  = cmd_ready_q;
  assign s.res_valid  = res_valid_q;
  assign s.res_data   = res_data_q;
  assign s.res_count  = res_count_q;
  assign s.busy       = busy_q;
  // job FSM; remaining only decrements from nonzero and leaves STREAM at 1, so it never wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      len_q       <= '0;
      clr_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      cmd_ready_q <= 1'b1;
      clr_q       <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          clr_q <= s.cmd_valid;
          if (s.cmd_valid) begin
            rem_q       <= s.cmd_len;
            len_q       <= s.cmd_len;
            clr_cnt_q   <= CW'(CLR_CYCLES - 1);
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q - CW'(1);
          drn_cnt_q <= DW'(MAC_LAT - 1);
          if (clr_cnt_q == '0) begin
            clr_q   <= 1'b0;
            state_q <= len_q != '0 ? STREAM : DRAIN;
          end
        end
        STREAM: begin
          if (s.op_valid) begin
            rem_q <= rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          drn_cnt_q <= drn_cnt_q - DW'(1);
          if (drn_cnt_q == '0) begin
            res_data_q  <= s.mac_out;
            res_count_q <= len_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (s.res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_fp4_dot_sequencer.sv
// tb_mac_fp4_dot_sequencer: directed jobs against a behavioural fp4 MAC, scoreboarded results
module tb_mac_fp4_dot_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  mac_fp4_dot_sequencer_if bus ();
  mac_fp4_dot_sequencer dut (.clk(clk), .reset_n(reset_n), .s(bus.slave));
  typedef struct {int data; int count; int lat;} exp_t;
  exp_t sbq[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int op_pulses = 0;
  int stall_left = 0;
  logic prev_v = 1'b0;
  logic signed [16:0] acc = '0;
  logic signed [16:0] p_q = '0;
  // fp4 e2m1 product in quarter units: magnitude codes are half units 0,.5,1,1.5,2,3,4,6
  function automatic logic signed [16:0] prod(input logic [3:0] w, input logic [3:0] a);
    int mag[8] = '{0, 1, 2, 3, 4, 6, 8, 12};
    int m;
    m = mag[w[2:0]] * mag[a[2:0]];
    return 17'((w[3] ^ a[3]) ? -m : m);
  endfunction
  // MAC: operand register then accumulator, both advance only on enable
  always @(posedge clk) begin
    if (bus.mac_clear) begin
      p_q <= '0;
      acc <= '0;
    end else if (bus.mac_en) begin
      p_q <= prod(bus.mac_weight, bus.mac_act);
      acc <= acc + p_q;
    end
  end
  assign bus.mac_out = acc;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // result consumer: stalls the next stall_left result cycles
  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.res_valid && stall_left > 0) begin
        bus.res_ready = 1'b0;
        stall_left--;
      end else bus.res_ready = 1'b1;
    end
  end
  // monitor: compares every presented result against the scoreboard head
  always @(negedge clk) begin
    if (!reset_n) prev_v = 1'b0;
    else begin
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
      if (bus.op_ready) begin
        op_pulses++;
        check("mac_en_vs_op_valid", int'(bus.mac_en), int'(bus.op_valid));
      end
      if (bus.res_valid) begin
        check("cmd_ready_in_done", int'(bus.cmd_ready), 0);
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got data %0d, expected no result", $signed(bus.res_data));
        end else begin
          if (!prev_v) check("latency", cyc - acc_cyc, sbq[0].lat);
          check("res_data", int'($signed(bus.res_data)), sbq[0].data);
          check("res_count", int'(bus.res_count), sbq[0].count);
          if (bus.res_ready) void'(sbq.pop_front());
        end
      end
      prev_v = bus.res_valid;
    end
  end
  task automatic start_job(input int len);
    int n = 0;
    bus.cmd_len = 9'(len);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      $display("FAIL cmd_timeout: got no cmd_ready, expected one within 2000 cycles");
      $fatal(1);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic send_pair(input logic [3:0] w, input logic [3:0] a);
    int n = 0;
    bus.op_weight = w;
    bus.op_act = a;
    bus.op_valid = 1'b1;
    @(negedge clk);
    while (!bus.op_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_ready) begin
      $display("FAIL op_timeout: got no op_ready, expected one within 2000 cycles");
      $fatal(1);
    end
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sbq.size(), 0);
    sbq.delete();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int p0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len = '0;
    bus.op_valid = 1'b0;
    bus.op_weight = '0;
    bus.op_act = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_mac_clear", int'(bus.mac_clear), 1);
    check("rst_mac_en", int'(bus.mac_en), 0);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_res_data", int'(bus.res_data), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    start_job(4);
    send_pair(4'h2, 4'h2);
    send_pair(4'h2, 4'h2);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_res_valid", int'(bus.res_valid), 0);
    check("abort_mac_clear", int'(bus.mac_clear), 1);
    check("abort_op_ready", int'(bus.op_ready), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    sbq.push_back(exp_t'{data: 4, count: 1, lat: 6});
    start_job(1);
    send_pair(4'h2, 4'h2);
    wait_drain();
    sbq.push_back(exp_t'{data: 142, count: 3, lat: 8});
    start_job(3);
    send_pair(4'h2, 4'h2);
    send_pair(4'h7, 4'h7);
    send_pair(4'hA, 4'h3);
    wait_drain();
    sbq.push_back(exp_t'{data: 142, count: 3, lat: 11});
    start_job(3);
    send_pair(4'h2, 4'h2);
    repeat (3) @(posedge clk);
    #1;
    send_pair(4'h7, 4'h7);
    send_pair(4'hA, 4'h3);
    wait_drain();
    p0 = op_pulses;
    sbq.push_back(exp_t'{data: 0, count: 0, lat: 5});
    start_job(0);
    wait_drain();
    check("len0_op_ready_pulses", op_pulses - p0, 0);
    stall_left = 4;
    sbq.push_back(exp_t'{data: -288, count: 2, lat: 7});
    sbq.push_back(exp_t'{data: 1, count: 1, lat: 6});
    start_job(2);
    send_pair(4'h7, 4'hF);
    send_pair(4'h7, 4'hF);
    start_job(1);
    send_pair(4'h1, 4'h1);
    wait_drain();
    sbq.push_back(exp_t'{data: -57488, count: 511, lat: 516});
    start_job(511);
    for (int i = 0; i < 511; i++) send_pair(4'h7, 4'h7);
    wait_drain();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected one before 500000 time units");
    $fatal(1);
  end
endmodule

// File: doc/mac_fp4_dot_sequencer.md
Name: mac_fp4_dot_sequencer

Overview:
- Sequences one fp4 e2m1 MAC unit through complete dot-product jobs: clear, stream K operand pairs, drain, capture result.
- Accepts a job length on a command handshake and operand pairs on a stream handshake, and drives the MAC's en, clear and operand inputs.
- Presents each finished accumulator value on a result handshake.
- Sits between the operand buffers and the MAC array column.

Parameters:
LEN_WIDTH, 9, width of job length; max K = 2**LEN_WIDTH-1
ACC_WIDTH, 17, MAC accumulator / result width
MAC_LAT, 2, cycles from a mac_en cycle until its product is reflected in mac_out
CLR_CYCLES, 2, cycles mac_clear is held high per job

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  job request
cmd_ready  output  1  sequencer idle, can accept job
cmd_len  input  LEN_WIDTH  number of operand pairs in job (0 legal)
op_valid  input  1  operand pair available
op_ready  output  1  sequencer consumes pair this cycle
op_weight  input  4  fp4 {sign,exp[1:0],man}
op_act  input  4  fp4 {sign,exp[1:0],man}
mac_en  output  1  MAC operand-capture / accumulate enable
mac_clear  output  1  MAC synchronous active-high clear
mac_weight  output  4  operand to MAC
mac_act  output  4  operand to MAC
mac_out  input  ACC_WIDTH  MAC accumulator value, signed
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  ACC_WIDTH  signed dot-product result
res_count  output  LEN_WIDTH  pairs accumulated for this result
busy  output  1  state != IDLE

Behaviour:
- MAC contract: the MAC accumulates only on mac_en cycles. mac_clear zeroes both its operand register and its accumulator.
- Reset (reset_n low, async):
  - state=IDLE; res_valid=0; res_data=0; res_count=0; counters=0.
  - mac_en=0; mac_weight=mac_act=0.
  - mac_clear=1 while reset_n is low.
  - Reset mid-job aborts the job. The partial result is discarded and no res_valid is produced.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_len into remaining and into len_q, load clr_cnt=CLR_CYCLES-1, go to CLEAR.
- CLEAR:
  - mac_clear=1 and mac_en=0.
  - Count clr_cnt down to 0.
  - Then go to STREAM if len_q!=0, else go to DRAIN.
- STREAM:
  - op_ready=1.
  - Pass-through (combinational): mac_en = op_valid; mac_weight/mac_act = op_weight/op_act when op_valid, else 0.
  - Each accepted pair decrements remaining.
  - The acceptance that takes remaining to 0 moves to DRAIN.
  - op_valid low gives a bubble: mac_en=0 and no state change.
- DRAIN:
  - mac_en=1 with mac_weight=mac_act=4'h0 (product 0), for MAC_LAT cycles (drn_cnt).
  - On the last DRAIN cycle's clock edge: res_data<=mac_out, res_count<=len_q, go to DONE.
- DONE:
  - res_valid=1; res_data and res_count are held stable.
  - On res_ready: go to IDLE on that edge.
  - cmd_ready=0 in DONE; no overlap of jobs.
- cmd_valid outside IDLE is ignored (not accepted).
- op_ready=0 outside STREAM. Operands presented then are not consumed.
- Arithmetic: the sequencer does no arithmetic on data; the result is the MAC accumulator as-is. It wraps modulo 2**ACC_WIDTH and is not saturated.
- Latency:
  - len=K with no bubbles: cmd accept to res_valid = 1 + CLR_CYCLES + K + MAC_LAT cycles.
  - len=0: 1 + CLR_CYCLES + MAC_LAT cycles, with res_data=0.
- Simultaneous events:
  - In DONE, res_ready and cmd_valid in the same cycle: return to IDLE; the command is accepted on the next cycle.
  - Maximum len (2**LEN_WIDTH-1): remaining must not wrap.

Test Plan:
1. Reset_n low mid-STREAM (after 2 of 4 pairs), then high: busy=0, res_valid=0, mac_clear=1 during reset; a new len=1 job of (0x2,0x2) then yields res_data=4.
2. len=3 pairs (0x2,0x2),(0x7,0x7),(0xA,0x3), no bubbles: res_data=142 (4+144-6), res_count=3, res_valid exactly 1+2+3+2=8 cycles after cmd accept.
3. Same as test 2 with op_valid low for 3 cycles between pairs 1 and 2: mac_en low during the gap, res_data=142, res_valid 3 cycles later than in test 2.
4. len=0 job: no op_ready pulse, res_data=0, res_count=0, res_valid 5 cycles after cmd accept.
5. Back-to-back jobs, (0x7,0xF)x2 then (0x1,0x1)x1, res_ready held low 4 cycles on the first result: first res_data=-288 stable while stalled, cmd_ready=0 until released; second res_data=1 (clear verified, no carry-over).
6. len=511 job of (0x7,0x7): res_data = 511*144 mod 2**17 reinterpreted as signed (73584 → -57488), res_count=511, remaining does not wrap.
